// File: rtl/copy_cmd_queue.sv
// copy_cmd_queue
//
// Command queue and sequencer in front of copy_engine. Buffer-copy
// descriptors {src, dst} arrive over a valid/ready handshake and are
// stored in a circular FIFO. They are issued to copy_engine one at a
// time: the addresses are registered and held, start is pulsed for one
// cycle, and the sequencer waits for done. Completions are counted.
//
// Optional feature: define COPY_QUEUE_TIMEOUT_EN to add a WAIT
// watchdog. If done does not arrive within TIMEOUT_CYCLES WAIT cycles,
// err_timeout is set (sticky) and the sequencer parks in FAULT until
// reset. Without the macro err_timeout is tied low and FAULT is
// unreachable.
//
// Parameters
//   DEPTH           FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES  watchdog limit in WAIT cycles (timeout build only)
//
// Ports
//   clk           sole clock
//   rst           asynchronous, active-high reset
//   cmd_valid     descriptor present
//   cmd_ready     queue can accept (not full)
//   cmd_src       source address of descriptor
//   cmd_dst       destination address of descriptor
//   eng_src_addr  source address to copy_engine, held from pop to pop
//   eng_dst_addr  destination address to copy_engine, held from pop to pop
//   eng_start     one-cycle start pulse to copy_engine
//   eng_done      completion from copy_engine
//   busy          sequencer not IDLE, or FIFO non-empty
//   level         FIFO occupancy
//   cmpl_pulse    one cycle per completed copy
//   cmpl_count    completed copies, wraps 0xFFFF -> 0
//   err_timeout   sticky watchdog fault
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no copy in flight; pops the head when the FIFO is non-empty
// ISSUE | eng_start high for this single cycle
// WAIT  | copy in flight, waiting for eng_done
// FAULT | watchdog expired; no further issue, exit by reset only

module copy_cmd_queue #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [63:0]                cmd_src,
    input  logic [63:0]                cmd_dst,
    output logic [63:0]                eng_src_addr,
    output logic [63:0]                eng_dst_addr,
    output logic                       eng_start,
    input  logic                       eng_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       cmpl_pulse,
    output logic [15:0]                cmpl_count,
    output logic                       err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("copy_cmd_queue: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("copy_cmd_queue: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit so full and empty differ.
    // ------------------------------------------------------------------
    logic [127:0]  mem [DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(DEPTH));
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    // Pop only in IDLE; FAULT never drains, so the queue fills up there.
    assign pop        = (state == IDLE) && !fifo_empty;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_src, cmd_dst};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
`ifdef COPY_QUEUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Down-counter loaded on entry to WAIT; terminal count 0 on a WAIT
    // cycle without done is the TIMEOUT_CYCLES-th such cycle.
    logic [TW-1:0] wdog_cnt;
    logic          err_q;

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            eng_start    <= 1'b0;
            eng_src_addr <= '0;
            eng_dst_addr <= '0;
            cmpl_pulse   <= 1'b0;
            cmpl_count   <= '0;
`ifdef COPY_QUEUE_TIMEOUT_EN
            wdog_cnt     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            eng_start  <= 1'b0;
            cmpl_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        {eng_src_addr, eng_dst_addr} <= mem[rd_ptr[AW-1:0]];
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef COPY_QUEUE_TIMEOUT_EN
                    wdog_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        cmpl_pulse <= 1'b1;
                        cmpl_count <= cmpl_count + 16'd1;
                        state      <= IDLE;
                    end
`ifdef COPY_QUEUE_TIMEOUT_EN
                    else if (wdog_cnt == '0) begin
                        err_q <= 1'b1;
                        state <= FAULT;
                    end else begin
                        wdog_cnt <= wdog_cnt - TW'(1);
                    end
`endif
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
